imm_decode_stage: RTL and testbench

Registered immediate-decode pipeline stage for the unicycle processor's migration to a pipelined core. Accepts a 32-bit RV32I/RV64I instruction with its PC over a valid/ready handshake and classifies its immediate format. It produces the XLEN-wide sign- or zero-extended immediate and flags illegal encodings. It sits between fetch and register-read, and a saturating counter records illegal instructions.

---
 rtl/imm_pkg.sv | 37 +++
 rtl/imm_decode_stage_if.sv | 28 ++
 rtl/imm_extract.sv | 61 ++++++
 rtl/imm_decode_stage.sv | 86 ++++++++
 tb/tb_imm_decode_stage.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/imm_pkg.sv
// Shared opcode constants, immediate format codes and the decode result type
// for the immediate-decode stage and anything else that needs RV immediates.
package imm_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int MAX_XLEN = 64;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6
    } fmt_e;

    // imm is always built at the widest XLEN; narrower users take the low bits,
    // which is exact because every format is sign- or zero-extended.
    typedef struct packed {
        logic [MAX_XLEN-1:0] imm;
        fmt_e                fmt;
        logic                illegal;
    } decode_t;

endpackage

// File: rtl/imm_decode_stage_if.sv
// Upstream/downstream valid-ready bundle of the immediate-decode stage.
interface imm_decode_stage_if
    import imm_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    fmt_e            out_fmt;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_extract.sv
// Combinational RV32I/RV64I immediate extractor: classifies the format and
// produces the extended immediate plus an illegal-encoding flag.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] instr,
    output decode_t     dec
);
    logic [6:0] opc;
    logic [2:0] f3;
    logic       s;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign s   = instr[31];

    // Every listed opcode ends in 2'b11, so compressed encodings fall to default.
    always_comb begin
        dec = '0;
        unique case (opc)
            OPC_OP_IMM: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    if (XLEN == 32 && instr[25]) begin
                        dec.illegal = 1'b1;
                    end else begin
                        dec.fmt = FMT_SH;
                        if (XLEN == 32) dec.imm = {59'd0, instr[24:20]};
                        else            dec.imm = {58'd0, instr[25:20]};
                    end
                end else begin
                    dec.fmt = FMT_I;
                    dec.imm = {{52{s}}, instr[31:20]};
                end
            end
            OPC_LOAD, OPC_JALR: begin
                dec.fmt = FMT_I;
                dec.imm = {{52{s}}, instr[31:20]};
            end
            OPC_STORE: begin
                dec.fmt = FMT_S;
                dec.imm = {{52{s}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                dec.fmt = FMT_B;
                dec.imm = {{52{s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.fmt = FMT_U;
                dec.imm = {{32{s}}, instr[31:12], 12'd0};
            end
            OPC_JAL: begin
                dec.fmt = FMT_J;
                dec.imm = {{44{s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_OP, OPC_FENCE, OPC_SYSTEM: dec.fmt = FMT_NONE;
            default: dec.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode pipeline stage with optional skid buffer and a
// saturating count of accepted illegal instructions.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    imm_decode_stage_if.slave bus,
    output logic [CNT_W-1:0] illegal_cnt
);
    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } entry_t;

    decode_t dec;
    entry_t  new_e, main_q, skid_q, main_d, skid_d;
    logic    main_valid, skid_valid, main_v_d, skid_v_d;
    logic    accept, xfer;

    imm_extract #(.XLEN(XLEN)) u_extract (.instr(bus.in_instr), .dec(dec));

    assign new_e = '{instr: bus.in_instr, pc: bus.in_pc, imm: dec.imm[XLEN-1:0],
                     fmt: dec.fmt, illegal: dec.illegal};

    assign bus.in_ready = (SKID != 0) ? !skid_valid : (!main_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign xfer         = main_valid && bus.out_ready;

    // Skid is only ever filled while main is stalled, so it always drains first.
    always_comb begin
        main_v_d = main_valid;
        skid_v_d = skid_valid;
        main_d   = main_q;
        skid_d   = skid_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (xfer && skid_valid) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
        end else if (xfer || !main_valid) begin
            main_v_d = accept;
            if (accept) main_d = new_e;
        end else if (accept && SKID != 0) begin
            skid_v_d = 1'b1;
            skid_d   = new_e;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_valid <= main_v_d;
            skid_valid <= skid_v_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_cnt <= '0;
        else if (accept && !flush && dec.illegal && !(&illegal_cnt))
            illegal_cnt <= illegal_cnt + 1'b1;
    end

    assign bus.out_valid   = main_valid;
    assign bus.out_instr   = main_q.instr;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_illegal = main_q.illegal;
endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench: a 32-bit skid-buffered stage (2-bit counter) and a 64-bit
// single-register stage driven side by side with the same instruction stream.
module tb_imm_decode_stage;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  cnt32;
    logic [15:0] cnt64;
    int          total = 0;
    int          bad = 0;

    imm_decode_stage_if #(.XLEN(32)) b32 ();
    imm_decode_stage_if #(.XLEN(64)) b64 ();

    imm_decode_stage #(.XLEN(32), .SKID(1), .CNT_W(2)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32), .illegal_cnt(cnt32));
    imm_decode_stage #(.XLEN(64), .SKID(0), .CNT_W(16)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64), .illegal_cnt(cnt64));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc);
        b32.in_valid = v;  b32.in_instr = ins;  b32.in_pc = pc[31:0];
        b64.in_valid = v;  b64.in_instr = ins;  b64.in_pc = pc;
    endtask

    task automatic set_ready(input logic r);
        b32.out_ready = r;
        b64.out_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 32'h0, 64'h0);
        set_ready(1'b0);
        step(); step();
        chk("rst_valid32", b32.out_valid, 0);
        chk("rst_ready32", b32.in_ready, 1);
        chk("rst_ready64", b64.in_ready, 1);
        chk("rst_imm32", b32.out_imm, 0);
        chk("rst_fmt32", b32.out_fmt, FMT_NONE);
        chk("rst_cnt32", cnt32, 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready32", b32.in_ready, 1);

        // Streaming with out_ready high: one result per cycle.
        set_ready(1'b1);
        drive(1'b1, 32'hFFF00093, 64'h100);  // addi x1,x0,-1
        step();
        chk("addi_valid", b32.out_valid, 1);
        chk("addi_imm32", b32.out_imm, 64'hFFFFFFFF);
        chk("addi_fmt", b32.out_fmt, FMT_I);
        chk("addi_ill", b32.out_illegal, 0);
        chk("addi_pc", b32.out_pc, 64'h100);
        chk("addi_imm64", b64.out_imm, 64'hFFFFFFFFFFFFFFFF);
        drive(1'b1, 32'hFE112E23, 64'h104);  // sw
        step();
        chk("sw_imm32", b32.out_imm, 64'hFFFFFFFC);
        chk("sw_fmt", b32.out_fmt, FMT_S);
        chk("sw_imm64", b64.out_imm, 64'hFFFFFFFFFFFFFFFC);
        drive(1'b1, 32'hFF9FF06F, 64'h108);  // jal -8
        step();
        chk("jal_imm32", b32.out_imm, 64'hFFFFFFF8);
        chk("jal_fmt", b32.out_fmt, FMT_J);
        chk("jal_instr", b32.out_instr, 64'hFF9FF06F);
        drive(1'b1, 32'h4200D093, 64'h10C);  // srai x1,x1,32
        step();
        chk("srai_ill32", b32.out_illegal, 1);
        chk("srai_fmt32", b32.out_fmt, FMT_NONE);
        chk("srai_imm32", b32.out_imm, 0);
        chk("srai_cnt32", cnt32, 1);
        chk("srai_imm64", b64.out_imm, 64'd32);
        chk("srai_fmt64", b64.out_fmt, FMT_SH);
        chk("srai_ill64", b64.out_illegal, 0);
        chk("srai_cnt64", cnt64, 0);
        drive(1'b1, 32'h00000000, 64'h110);
        step();
        chk("zero_ill32", b32.out_illegal, 1);
        chk("zero_fmt32", b32.out_fmt, FMT_NONE);
        chk("zero_imm32", b32.out_imm, 0);
        chk("zero_cnt32", cnt32, 2);
        chk("zero_cnt64", cnt64, 1);
        drive(1'b0, 32'h0, 64'h0);
        step();
        chk("drain_valid", b32.out_valid, 0);

        // Backpressure: A to main, B to skid, C waits.
        set_ready(1'b0);
        drive(1'b1, 32'h00100093, 64'h200);
        step();
        chk("bp_a_valid", b32.out_valid, 1);
        chk("bp_a_ready", b32.in_ready, 1);
        chk("bp_a_ready64", b64.in_ready, 0);
        drive(1'b1, 32'h00200093, 64'h204);
        step();
        chk("bp_b_ready", b32.in_ready, 0);
        chk("bp_b_pc", b32.out_pc, 64'h200);
        drive(1'b1, 32'h00300093, 64'h208);
        step();
        chk("bp_c_ready", b32.in_ready, 0);
        chk("bp_c_pc", b32.out_pc, 64'h200);
        chk("bp_c_imm", b32.out_imm, 64'd1);
        set_ready(1'b1);
        #1;
        chk("bp_c_ready64", b64.in_ready, 1);
        step();
        chk("bp_out_b", b32.out_pc, 64'h204);
        chk("bp_out_b_imm", b32.out_imm, 64'd2);
        chk("bp_ready_back", b32.in_ready, 1);
        chk("bp_out64", b64.out_pc, 64'h208);
        step();
        chk("bp_out_c", b32.out_pc, 64'h208);
        chk("bp_out_c_imm", b32.out_imm, 64'd3);
        drive(1'b0, 32'h0, 64'h0);
        step();
        chk("bp_drained", b32.out_valid, 0);

        // Counter saturation at 2 bits.
        drive(1'b1, 32'h00000000, 64'h300);
        step();
        chk("sat_cnt_a", cnt32, 3);
        step();
        step();
        chk("sat_cnt_b", cnt32, 3);
        chk("sat_cnt64", cnt64, 4);

        // Flush with both entries held and a live input.
        set_ready(1'b0);
        drive(1'b1, 32'h00100093, 64'h400);
        step();
        drive(1'b1, 32'h00200093, 64'h404);
        step();
        chk("fl_pre_ready", b32.in_ready, 0);
        set_ready(1'b1);
        drive(1'b1, 32'h00000000, 64'h408);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 64'h0);
        chk("fl_valid32", b32.out_valid, 0);
        chk("fl_valid64", b64.out_valid, 0);
        chk("fl_cnt64", cnt64, 4);
        chk("fl_ready32", b32.in_ready, 1);
        step();
        chk("fl_stay_empty", b32.out_valid, 0);

        // Async reset mid-stream.
        drive(1'b1, 32'hFFF00093, 64'h500);
        step();
        chk("mid_valid", b32.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid32", b32.out_valid, 0);
        chk("ar_pc32", b32.out_pc, 0);
        chk("ar_imm32", b32.out_imm, 0);
        chk("ar_cnt32", cnt32, 0);
        chk("ar_cnt64", cnt64, 0);
        chk("ar_valid64", b64.out_valid, 0);
        chk("ar_ready32", b32.in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
